// File: rtl/cvec_pkg.sv
// rtl/cvec_pkg.sv - shared widths, FSM states and op encoding for the complex-vector scale/add/sub engine
package cvec_pkg;

    localparam int DEF_LANES  = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 8;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // One complex element is a real half stacked above an imaginary half.
    function automatic int comp_width(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/cvec_lane_mac.sv
// rtl/cvec_lane_mac.sv - one lane: complex multiply, shift, add/sub and reduce (CVEC_SATURATE_EN selects saturation)
module cvec_lane_mac
    import cvec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*DATA_W-1:0]   c,
    input  op_e                   op,
    input  logic [2*DATA_W-1:0]   a,
    input  logic [2*DATA_W-1:0]   b,
    input  logic                  out_en,
    output logic [2*DATA_W-1:0]   result
);

    localparam int PW = 2 * DATA_W;
    localparam int SW = PW + 1;
    localparam int RW = DATA_W + 2;

    logic signed [DATA_W-1:0] c_re, c_im, b_re, b_im;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
    logic signed [RW-1:0]     s_re, s_im;
    logic [PW-1:0]            a1, a2;

    assign c_re = c[PW-1:DATA_W];
    assign c_im = c[DATA_W-1:0];
    assign b_re = b[PW-1:DATA_W];
    assign b_im = b[DATA_W-1:0];

    function automatic logic signed [RW-1:0] addsub(input op_e o,
                                                    input logic signed [DATA_W-1:0] x,
                                                    input logic signed [RW-1:0] p);
        logic signed [RW-1:0] xe;
        xe = RW'(x);
        return (o == OP_SUB) ? xe - p : xe + p;
    endfunction

    function automatic logic [DATA_W-1:0] reduce(input logic signed [RW-1:0] v);
`ifdef CVEC_SATURATE_EN
        if (v[RW-1:DATA_W-1] == '0 || v[RW-1:DATA_W-1] == '1)
            return v[DATA_W-1:0];
        else if (v[RW-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
`else
        return DATA_W'(v);
`endif
    endfunction

    // A rides alongside the products so it meets them at the add/sub stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
            a1   <= '0;
        end else begin
            p_rr <= PW'(c_re) * PW'(b_re);
            p_ii <= PW'(c_im) * PW'(b_im);
            p_ri <= PW'(c_re) * PW'(b_im);
            p_ir <= PW'(c_im) * PW'(b_re);
            a1   <= a;
        end
    end

    // Combine at full precision, floor-shift by FRAC_W, keep DATA_W+2 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_re <= '0;
            s_im <= '0;
            a2   <= '0;
        end else begin
            s_re <= RW'((SW'(p_rr) - SW'(p_ii)) >>> FRAC_W);
            s_im <= RW'((SW'(p_ri) + SW'(p_ir)) >>> FRAC_W);
            a2   <= a1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
        end else if (out_en) begin
            result <= {reduce(addsub(op, a2[PW-1:DATA_W], s_re)),
                       reduce(addsub(op, a2[DATA_W-1:0], s_im))};
        end
    end

endmodule

// File: rtl/cvec_scale_addsub.sv
// rtl/cvec_scale_addsub.sv - streaming R[k] = A[k] +/- c*B[k] row engine (CVEC_SATURATE_EN enables saturation)
module cvec_scale_addsub
    import cvec_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        op,
    input  logic [2*DATA_W-1:0]         constant,
    input  logic [ADDR_W-1:0]           num_rows,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [LANES*2*DATA_W-1:0]   row_a,
    input  logic [LANES*2*DATA_W-1:0]   row_b,
    output logic                        result_we,
    output logic [ADDR_W-1:0]           result_addr,
    output logic [LANES*2*DATA_W-1:0]   result_data,
    output logic                        busy,
    output logic                        finish
);

    localparam int COMP_W = comp_width(DATA_W);

    state_e              state, state_nxt;
    op_e                 op_q;
    logic [COMP_W-1:0]   c_q;
    logic [ADDR_W-1:0]   rows_q, addr_q;
    logic [ADDR_W-1:0]   addr_d1, addr_d2, addr_d3;
    logic [2:0]          vld_q;

    assign rd_addr = addr_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // DRAIN leaves one cycle before the last write so the registered finish lands right after it.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (start) state_nxt = (num_rows == '0) ? DONE : RUN;
            RUN: begin
                rd_en = 1'b1;
                if (addr_q == rows_q - 1'b1) state_nxt = DRAIN;
            end
            DRAIN: if (vld_q[2] && !vld_q[1] && !vld_q[0]) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OP_ADD;
            c_q         <= '0;
            rows_q      <= '0;
            addr_q      <= '0;
            addr_d1     <= '0;
            addr_d2     <= '0;
            addr_d3     <= '0;
            vld_q       <= '0;
            result_we   <= 1'b0;
            result_addr <= '0;
            finish      <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                op_q   <= op_e'(op);
                c_q    <= constant;
                rows_q <= num_rows;
            end
            if (state == RUN)
                addr_q <= (state_nxt == DRAIN) ? '0 : addr_q + 1'b1;
            vld_q     <= {vld_q[1:0], rd_en};
            addr_d1   <= addr_q;
            addr_d2   <= addr_d1;
            addr_d3   <= addr_d2;
            result_we <= vld_q[2];
            if (vld_q[2]) result_addr <= addr_d3;
            finish    <= (state == DONE);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cvec_lane_mac #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .c      (c_q),
            .op     (op_q),
            .a      (row_a[i*COMP_W +: COMP_W]),
            .b      (row_b[i*COMP_W +: COMP_W]),
            .out_en (vld_q[2]),
            .result (result_data[i*COMP_W +: COMP_W])
        );
    end

endmodule

// File: tb/tb_cvec_scale_addsub.sv
// tb/tb_cvec_scale_addsub.sv - directed scoreboard bench for cvec_scale_addsub
module tb_cvec_scale_addsub;

    localparam int LANES = 8;
    localparam int DW    = 16;
    localparam int FW    = 8;
    localparam int AW    = 8;
    localparam int ROW_W = LANES * 2 * DW;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [ROW_W-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset, start, op;
    logic [2*DW-1:0]    constant;
    logic [AW-1:0]      num_rows;
    logic               rd_en, result_we, busy, finish;
    logic [AW-1:0]      rd_addr, result_addr;
    logic [ROW_W-1:0]   row_a = '0, row_b = '0, result_data;

    logic [ROW_W-1:0]   mem_a [256];
    logic [ROW_W-1:0]   mem_b [256];
    exp_t               sbq [$];

    int checks = 0, errors = 0, cyc = 0;
    int we_cnt, rd_cnt, fin_cnt, first_we_cyc, last_we_cyc, fin_cyc, busy_gap, start_cyc;

    cvec_scale_addsub #(.LANES(LANES), .DATA_W(DW), .FRAC_W(FW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .constant(constant),
        .num_rows(num_rows), .rd_en(rd_en), .rd_addr(rd_addr), .row_a(row_a),
        .row_b(row_b), .result_we(result_we), .result_addr(result_addr),
        .result_data(result_data), .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) if (rd_en) begin
        row_a <= mem_a[rd_addr];
        row_b <= mem_b[rd_addr];
    end

    task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint trunc18(input longint v);
        return (v <<< 46) >>> 46;
    endfunction

    function automatic logic [DW-1:0] red(input longint v);
        longint t;
        t = trunc18(v);
`ifdef CVEC_SATURATE_EN
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
`endif
        return t[DW-1:0];
    endfunction

    function automatic logic [31:0] lane_model(input logic [31:0] c, input logic [31:0] a,
                                               input logic [31:0] b, input logic sub);
        longint cr, ci, ar, ai, br, bi, pr, pi;
        cr = $signed(c[31:16]); ci = $signed(c[15:0]);
        ar = $signed(a[31:16]); ai = $signed(a[15:0]);
        br = $signed(b[31:16]); bi = $signed(b[15:0]);
        pr = trunc18((cr * br - ci * bi) >>> FW);
        pi = trunc18((cr * bi + ci * br) >>> FW);
        return {red(sub ? ar - pr : ar + pr), red(sub ? ai - pi : ai + pi)};
    endfunction

    function automatic logic [ROW_W-1:0] model_row(input logic [31:0] c, input logic sub,
                                                   input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*32 +: 32] = lane_model(c, a[i*32 +: 32], b[i*32 +: 32], sub);
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] rep(input logic [31:0] v);
        return {LANES{v}};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rd_en) rd_cnt++;
        if (finish) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
        if (result_we) begin
            we_cnt++;
            if (we_cnt == 1) first_we_cyc = cyc;
            last_we_cyc = cyc;
            if (!busy) busy_gap++;
            if (sbq.size() == 0) begin
                check("unexpected_write", ROW_W'(result_addr), '1);
            end else begin
                e = sbq.pop_front();
                check("wr_addr", ROW_W'(result_addr), ROW_W'(e.addr));
                check("wr_data", result_data, e.data);
            end
        end
    end

    task automatic clear_counts();
        we_cnt = 0; rd_cnt = 0; fin_cnt = 0; busy_gap = 0;
        first_we_cyc = -1; last_we_cyc = -1; fin_cyc = -1;
    endtask

    task automatic start_run(input logic [31:0] c, input logic sub, input int n);
        @(negedge clk);
        clear_counts();
        constant = c; op = sub; num_rows = AW'(n); start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        constant = $urandom; op = ~sub; num_rows = AW'($urandom);
    endtask

    task automatic push_model(input logic [31:0] c, input logic sub, input int n);
        for (int k = 0; k < n; k++)
            sbq.push_back('{AW'(k), model_row(c, sub, mem_a[k], mem_b[k])});
    endtask

    task automatic wait_done(input string tag, input int n);
        int i;
        for (i = 0; i < 600 && fin_cnt == 0; i++) @(negedge clk);
        check({tag, "_finish_seen"}, ROW_W'(fin_cnt != 0), 1);
        repeat (4) @(negedge clk);
        check({tag, "_finish_count"}, ROW_W'(fin_cnt), 1);
        check({tag, "_write_count"}, ROW_W'(we_cnt), ROW_W'(n));
        check({tag, "_sb_empty"}, ROW_W'(sbq.size()), 0);
        if (n > 0) begin
            check({tag, "_first_latency"}, ROW_W'(first_we_cyc - start_cyc), 5);
            check({tag, "_finish_latency"}, ROW_W'(fin_cyc - last_we_cyc), 1);
        end else begin
            check({tag, "_finish_latency"}, ROW_W'(fin_cyc - start_cyc), 2);
            check({tag, "_no_reads"}, ROW_W'(rd_cnt), 0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, ROW_W'(rd_en), 0);
        check({tag, "_rd_addr"}, ROW_W'(rd_addr), 0);
        check({tag, "_we"}, ROW_W'(result_we), 0);
        check({tag, "_waddr"}, ROW_W'(result_addr), 0);
        check({tag, "_wdata"}, result_data, 0);
        check({tag, "_busy"}, ROW_W'(busy), 0);
        check({tag, "_finish"}, ROW_W'(finish), 0);
    endtask

    initial begin
        int i;
        reset = 1'b1; start = 1'b0; op = 1'b0; constant = '0; num_rows = '0;
        clear_counts();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        // 2.0 * 1.0 subtracted from 1.0
        mem_a[0] = rep(32'h0100_0000); mem_b[0] = rep(32'h0100_0000);
        sbq.push_back('{8'd0, rep(32'hFF00_0000)});
        start_run(32'h0200_0000, 1'b1, 1);
        wait_done("sub_one", 1);

        // j * 1.0 added to zero
        mem_a[0] = '0; mem_b[0] = rep(32'h0100_0000);
        sbq.push_back('{8'd0, rep(32'h0000_0100)});
        start_run(32'h0000_0100, 1'b0, 1);
        wait_done("mul_j", 1);

        // overflow: 127 + 254
        mem_a[0] = rep(32'h7F00_0000); mem_b[0] = rep(32'h7F00_0000);
`ifdef CVEC_SATURATE_EN
        sbq.push_back('{8'd0, rep(32'h7FFF_0000)});
`else
        sbq.push_back('{8'd0, rep(32'h7D00_0000)});
`endif
        start_run(32'h0200_0000, 1'b0, 1);
        wait_done("overflow", 1);

        // 16 rows with B = 0: results equal A
        for (int k = 0; k < 16; k++) begin
            mem_a[k] = rep({8'(k), 24'h0});
            mem_b[k] = '0;
            sbq.push_back('{AW'(k), rep({8'(k), 24'h0})});
        end
        start_run(32'h0200_0000, 1'b0, 16);
        wait_done("rows16", 16);
        check("rows16_busy_gap", ROW_W'(busy_gap), 0);

        // zero rows
        start_run(32'h0100_0000, 1'b0, 0);
        wait_done("rows0", 0);

        // start during a run is ignored
        for (int k = 0; k < 16; k++) sbq.push_back('{AW'(k), rep({8'(k), 24'h0})});
        start_run(32'h0200_0000, 1'b0, 16);
        repeat (4) @(negedge clk);
        num_rows = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart_ignored", 16);

        // reset in the middle of a run
        for (int k = 0; k < 16; k++) sbq.push_back('{AW'(k), rep({8'(k), 24'h0})});
        start_run(32'h0200_0000, 1'b0, 16);
        for (i = 0; i < 50 && !(rd_en && rd_addr == 8'd5); i++) @(negedge clk);
        check("abort_reached_row5", ROW_W'(rd_en && rd_addr == 8'd5), 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        reset = 1'b0;
        sbq.delete();
        clear_counts();
        repeat (12) @(negedge clk);
        check("abort_no_writes", ROW_W'(we_cnt), 0);
        check("abort_no_finish", ROW_W'(fin_cnt), 0);

        // random rows against the arithmetic model
        for (int k = 0; k < 6; k++) begin
            for (int w = 0; w < ROW_W / 32; w++) begin
                mem_a[k][w*32 +: 32] = $urandom;
                mem_b[k][w*32 +: 32] = $urandom;
            end
        end
        push_model(32'h0180_FF40, 1'b1, 6);
        start_run(32'h0180_FF40, 1'b1, 6);
        wait_done("random_sub", 6);
        push_model(32'hFE80_0260, 1'b0, 6);
        start_run(32'hFE80_0260, 1'b0, 6);
        wait_done("random_add", 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cvec_scale_addsub.md
Name: cvec_scale_addsub

Overview:
- Streaming complex-vector engine: for rows k = 0..num_rows-1, computes R[k] = A[k] ± c·B[k], lane-wise, with c a complex constant.
- Drives read addresses into two row memories (A and B).
- Writes result rows through a write-enable/address port and pulses finish at the end.
- Parametrised successor of the fixed 8-lane mul/sub block: configurable lanes, width, row count and add/sub mode, with optional saturation.

Parameters:
- LANES, 8, complex elements per row.
- DATA_W, 16, bits per real/imag component (signed two's complement).
- FRAC_W, 8, fractional bits (fixed-point Q format, same for c, A, B, R).
- ADDR_W, 8, row address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- op  in  1  1 = subtract (A − c·B), 0 = add; latched at start.
- constant  in  2*DATA_W  c; real in [2*DATA_W-1:DATA_W], imag in [DATA_W-1:0]; latched at start.
- num_rows  in  ADDR_W  rows to process; latched at start.
- rd_en  out  1  read strobe to both row memories.
- rd_addr  out  ADDR_W  row address, shared by A and B.
- row_a  in  LANES*2*DATA_W  A row; valid exactly 1 cycle after rd_en.
- row_b  in  LANES*2*DATA_W  B row; same timing as row_a.
- result_we  out  1  result row write enable.
- result_addr  out  ADDR_W  result row address.
- result_data  out  LANES*2*DATA_W  result row.
- busy  out  1  high from the cycle after start until finish.
- finish  out  1  one-cycle pulse when the last row has been written.

Behaviour:
- Lane packing: lane i occupies bits [i*2*DATA_W +: 2*DATA_W]; real half is the upper DATA_W bits.
- Reset value of every output is 0; FSM returns to IDLE; all pipeline valids clear.
- Reset mid-run aborts the run: no further writes and no finish pulse.
- FSM states:
  - IDLE: start → latch op, constant and num_rows. If num_rows = 0, go to DONE; otherwise go to RUN.
  - RUN: one rd_en per cycle; rd_addr increments 0..num_rows-1. After issuing num_rows-1, go to DRAIN.
  - DRAIN: wait until the pipeline is empty (last result_we seen), then go to DONE.
  - DONE: finish = 1 for one cycle, then go to IDLE.
- start outside IDLE is ignored. Changes to op, constant or num_rows during a run have no effect.
- Pipeline (fully pipelined, one row per cycle):
  - T: rd_en/rd_addr = k.
  - T+1: row data valid, registered into stage 1.
  - T+2: four products per lane registered.
  - T+3: combine, arithmetic shift right by FRAC_W, registered.
  - T+4: add/sub A; result_we = 1, result_addr = k.
  - Fixed latency of 4 cycles from rd_en to result_we; A is delayed alongside the products.
- Arithmetic per lane:
  - pr = cr·br − ci·bi and pi = cr·bi + ci·br, at full precision (2*DATA_W+1 bits).
  - Shift right arithmetically by FRAC_W (truncation toward −∞).
  - R = A ± p, computed at DATA_W+2 bits, then reduced to DATA_W bits: wrap by default, see the optional feature.
- result_data holds its last value when result_we = 0.
- finish asserts exactly one cycle after the last result_we. For num_rows = 0: start at T gives finish at T+2 and no writes.
- num_rows = 2^ADDR_W − 1 is the maximum. rd_addr never wraps within a run.

Optional Feature:
- CVEC_SATURATE_EN defined: the final reduction of each component saturates to [−2^(DATA_W-1), 2^(DATA_W-1)−1].
- Not defined: two's-complement truncation (wrap) of the low DATA_W bits.
- Product and shift stages are identical in both builds.

Decomposition:
- Package cvec_pkg holds the lane/component slicing widths (e.g. COMP_W = 2*DATA_W), FSM state encoding (IDLE, RUN, DRAIN, DONE) and the op encoding constants (OP_ADD = 0, OP_SUB = 1).
- One sub-module, cvec_lane_mac: per-lane 3-stage datapath (multiply, combine/shift, add/sub/reduce), instantiated LANES times in a generate loop. The top level holds the FSM, address counters and valid/address delay line.

Test Plan (DATA_W=16, FRAC_W=8, LANES=8):
1. c = 0x0200_0000 (2.0), A = B = 0x0100_0000 in all lanes, op=1, num_rows=1 → one result_we at T+4, addr 0, every lane 0xFF00_0000 (−1.0); finish one cycle later.
2. c = 0x0000_0100 (j), A = 0, B = 0x0100_0000, op=0 → every lane 0x0000_0100 (0 + j1.0).
3. A = 0x7F00_0000, B = 0x7F00_0000, c = 2.0, op=0 → lanes 0x7D00_0000 without CVEC_SATURATE_EN; 0x7FFF_0000 with it.
4. num_rows=16, row k A = k·1.0, B = 0 → 16 consecutive result_we, addresses 0..15, data equal to A; busy high throughout; finish once.
5. num_rows=0 → no rd_en, no result_we, finish 2 cycles after start; start pulsed during a 16-row run → ignored, still exactly 16 writes.
6. reset asserted at row 5 of a 16-row run → all outputs 0 next cycle; no finish; a new start runs cleanly from address 0.
